// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential radix-2 Booth signed multiplier, one iteration per clock.
module booth_mult_seq #(
   parameter int N = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [N-1:0]   multiplicand,
   input  logic [N-1:0]   multiplier,
   output logic [2*N-1:0] product,
   output logic           busy,
   output logic           done
);
   localparam int CW = $clog2(N) + 1;
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t         state;
   logic [N:0]     a, m, sum, a_nxt;
   logic [N-1:0]   q, q_nxt;
   logic           q_1, armed;
   logic [CW-1:0]  cnt;
   // N+1-bit A keeps -M representable when M is the most negative operand
   always_comb begin
      sum   = ({q[0], q_1} == 2'b01) ? a + m : ({q[0], q_1} == 2'b10) ? a - m : a;
      a_nxt = {sum[N], sum[N:1]};
      q_nxt = {sum[0], q[N-1:1]};
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         a       <= '0;
         q       <= '0;
         q_1     <= 1'b0;
         m       <= '0;
         cnt     <= '0;
         product <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         armed   <= 1'b0;
      end else begin
         armed <= 1'b1;
         case (state)
            IDLE: if (start && armed) begin
               m     <= {multiplicand[N-1], multiplicand};
               q     <= multiplier;
               a     <= '0;
               q_1   <= 1'b0;
               cnt   <= CW'(N);
               busy  <= 1'b1;
               state <= CALC;
            end
            CALC: begin
               a   <= a_nxt;
               q   <= q_nxt;
               q_1 <= q[0];
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  product <= {a_nxt[N-1:0], q_nxt};
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state   <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
